// File: rtl/data_ram_responder.sv
// Data-memory slave: byte-masked stores, in-order load responses WAIT_CYCLES after reaching queue head.
// Loads are refused (mem_addr_ok=0) while RESP_DEPTH responses are outstanding; stores are always accepted.
module data_ram_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_DEPTH  = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_addr_ok,
  output logic                  mem_data_ok,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  data_ok_resp
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0]       WAIT_MAX = 4'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

  logic [DATA_WIDTH-1:0] resp_dat_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] resp_dat_d [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;

  logic [IDX_W-1:0] word_idx;
  logic             fifo_empty;
  logic             fifo_full;
  logic             store_acc;
  logic             load_acc;
  logic             pop;
  logic             unused_addr_bits;

  // Upper address bits wrap the array; the low two bits are the requester's sub-word select.
  assign word_idx         = mem_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{mem_addr[DATA_WIDTH-1:IDX_W+2], mem_addr[1:0]};

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign mem_addr_ok = mem_we | ~fifo_full;
  assign store_acc   = mem_req & mem_we;
  assign load_acc    = mem_req & ~mem_we & ~fifo_full;

  assign mem_data_ok = ~fifo_empty & (wait_cnt_q == WAIT_MAX);
  assign mem_rdata   = mem_data_ok ? resp_dat_q[rd_ptr_q] : '0;
  assign pop         = mem_data_ok & data_ok_resp;

  always_ff @(posedge clk) begin
    if (store_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) begin
          ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    resp_dat_d = resp_dat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(load_acc) - CNT_W'(pop);
    wait_cnt_d = wait_cnt_q;

    if (load_acc) begin
      resp_dat_d[wr_ptr_q] = ram[word_idx];
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Timer restarts for the next head on every pop; counts up only while a response is waiting.
    if (pop) begin
      wait_cnt_d = 4'd0;
    end else if (!fifo_empty && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    resp_dat_q <= resp_dat_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= 4'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=3, shared stimulus.
module tb_data_ram_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        data_ok_resp;

  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        w_addr_ok;
  logic        w_data_ok;
  logic [31:0] w_rdata;

  int vectors;
  int miscompares;

  data_ram_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .data_ok_resp (data_ok_resp)
  );

  data_ram_responder #(.WAIT_CYCLES(3)) dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (w_addr_ok),
    .mem_data_ok  (w_data_ok),
    .mem_rdata    (w_rdata),
    .data_ok_resp (data_ok_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL rst_addr_ok: got %b want 1", mem_addr_ok); end
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_data_ok: got %b want 0", mem_data_ok); end
    vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
    tick;
  endtask

  task automatic test_store_load;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'hF; mem_wdata = 32'hDEADBEEF;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL sl_st0_addr_ok: got %b want 1", mem_addr_ok); end
    tick;
    // Byte lane 1 takes wdata[15:8], which is 0x00 in this store.
    mem_addr = 32'h11; mem_wstrb = 4'b0010; mem_wdata = 32'h000000AA;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL sl_st1_addr_ok: got %b want 1", mem_addr_ok); end
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL sl_st0_no_resp: got %b want 0", mem_data_ok); end
    tick;
    mem_we = 1'b0; mem_addr = 32'h10;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL sl_ld_addr_ok: got %b want 1", mem_addr_ok); end
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL sl_st1_no_resp: got %b want 0", mem_data_ok); end
    tick;
    mem_req = 1'b0;
    #1;
    vectors++; if (mem_data_ok !== 1'b1) begin miscompares++; $display("FAIL sl_ld_data_ok: got %b want 1", mem_data_ok); end
    vectors++; if (mem_rdata !== 32'hDEAD00EF) begin miscompares++; $display("FAIL sl_ld_rdata: got %h want DEAD00EF", mem_rdata); end
    tick;
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL sl_single_resp: got %b want 0", mem_data_ok); end
    vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL sl_idle_rdata: got %h want 0", mem_rdata); end
    // Non-adjacent lanes 3 and 0 over the existing word.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h13; mem_wstrb = 4'b1001; mem_wdata = 32'h12345678;
    tick;
    mem_we = 1'b0; mem_addr = 32'h10;
    tick;
    mem_req = 1'b0;
    #1;
    vectors++; if (mem_data_ok !== 1'b1) begin miscompares++; $display("FAIL sl_mask_data_ok: got %b want 1", mem_data_ok); end
    vectors++; if (mem_rdata !== 32'h12AD0078) begin miscompares++; $display("FAIL sl_mask_rdata: got %h want 12AD0078", mem_rdata); end
    tick;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'(i * 4); mem_wstrb = 4'hF; mem_wdata = 32'(i);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      mem_we = 1'b0; mem_addr = 32'(i * 4);
      #1;
      vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_addr_ok[%0d]: got %b want 1", i, mem_addr_ok); end
      vectors++; if (mem_data_ok !== 1'(i > 0)) begin miscompares++; $display("FAIL b2b_data_ok[%0d]: got %b want %b", i, mem_data_ok, (i > 0)); end
      vectors++; if (mem_rdata !== ((i > 0) ? 32'(i - 1) : 32'h0)) begin miscompares++; $display("FAIL b2b_rdata[%0d]: got %h want %0d", i, mem_rdata, (i > 0) ? i - 1 : 0); end
      tick;
    end
    mem_req = 1'b0;
    #1;
    vectors++; if (mem_data_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_last_data_ok: got %b want 1", mem_data_ok); end
    vectors++; if (mem_rdata !== 32'h3) begin miscompares++; $display("FAIL b2b_last_rdata: got %h want 3", mem_rdata); end
    tick;
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %b want 0", mem_data_ok); end
  endtask

  task automatic test_full;
    logic [31:0] wv [3];
    wv[0] = 32'hA5A50005; wv[1] = 32'h5A5A0006; wv[2] = 32'h77770007;
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'((5 + i) * 4); mem_wstrb = 4'hF; mem_wdata = wv[i];
      tick;
    end
    data_ok_resp = 1'b0;
    mem_we = 1'b0; mem_addr = 32'd20;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL full_ld0_addr_ok: got %b want 1", mem_addr_ok); end
    tick;
    mem_addr = 32'd24;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL full_ld1_addr_ok: got %b want 1", mem_addr_ok); end
    vectors++; if (mem_rdata !== wv[0]) begin miscompares++; $display("FAIL full_head0_rdata: got %h want %h", mem_rdata, wv[0]); end
    tick;
    mem_addr = 32'd28;
    #1;
    vectors++; if (mem_addr_ok !== 1'b0) begin miscompares++; $display("FAIL full_ld2_refused: got %b want 0", mem_addr_ok); end
    vectors++; if (mem_data_ok !== 1'b1) begin miscompares++; $display("FAIL full_hold_data_ok: got %b want 1", mem_data_ok); end
    vectors++; if (mem_rdata !== wv[0]) begin miscompares++; $display("FAIL full_hold_rdata: got %h want %h", mem_rdata, wv[0]); end
    tick;
    mem_we = 1'b1; mem_addr = 32'd32; mem_wdata = 32'h00000088;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL full_store_accepted: got %b want 1", mem_addr_ok); end
    vectors++; if (mem_rdata !== wv[0]) begin miscompares++; $display("FAIL full_hold2_rdata: got %h want %h", mem_rdata, wv[0]); end
    tick;
    // Release back-pressure while the third load retries: no same-cycle pop bypass.
    mem_we = 1'b0; mem_addr = 32'd28; data_ok_resp = 1'b1;
    #1;
    vectors++; if (mem_addr_ok !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass: got %b want 0", mem_addr_ok); end
    vectors++; if (mem_rdata !== wv[0]) begin miscompares++; $display("FAIL full_pop0_rdata: got %h want %h", mem_rdata, wv[0]); end
    tick;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL full_ld2_accepted: got %b want 1", mem_addr_ok); end
    vectors++; if (mem_data_ok !== 1'b1) begin miscompares++; $display("FAIL full_pop1_data_ok: got %b want 1", mem_data_ok); end
    vectors++; if (mem_rdata !== wv[1]) begin miscompares++; $display("FAIL full_pop1_rdata: got %h want %h", mem_rdata, wv[1]); end
    tick;
    mem_addr = 32'd32;
    #1;
    vectors++; if (mem_rdata !== wv[2]) begin miscompares++; $display("FAIL full_pop2_rdata: got %h want %h", mem_rdata, wv[2]); end
    tick;
    mem_req = 1'b0;
    #1;
    vectors++; if (mem_rdata !== 32'h00000088) begin miscompares++; $display("FAIL full_store_readback: got %h want 00000088", mem_rdata); end
    tick;
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL full_drained: got %b want 0", mem_data_ok); end
  endtask

  task automatic test_wrap;
    mem_req = 1'b1; mem_we = 1'b1; mem_wstrb = 4'hF;
    mem_addr = 32'h0; mem_wdata = 32'h0BADF00D;
    tick;
    mem_addr = 32'h20000004; mem_wdata = 32'hC0FFEE01;
    tick;
    mem_we = 1'b0; mem_addr = 32'h1000;
    tick;
    mem_addr = 32'h4;
    #1;
    vectors++; if (mem_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL wrap_load_1000: got %h want 0BADF00D", mem_rdata); end
    tick;
    mem_req = 1'b0;
    #1;
    vectors++; if (mem_rdata !== 32'hC0FFEE01) begin miscompares++; $display("FAIL wrap_store_high: got %h want C0FFEE01", mem_rdata); end
    tick;
  endtask

  task automatic test_mid_reset;
    data_ok_resp = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0;
    tick;
    mem_addr = 32'h4;
    tick;
    mem_req = 1'b0;
    #1;
    vectors++; if (mem_addr_ok !== 1'b0) begin miscompares++; $display("FAIL mr_full_before: got %b want 0", mem_addr_ok); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; data_ok_resp = 1'b1;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL mr_addr_ok: got %b want 1", mem_addr_ok); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL mr_no_resp[%0d]: got %b want 0", k, mem_data_ok); end
      tick;
    end
    // Exactly RESP_DEPTH loads fit again, so the queue restarted empty.
    data_ok_resp = 1'b0;
    mem_req = 1'b1; mem_addr = 32'h0;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL mr_ld0_addr_ok: got %b want 1", mem_addr_ok); end
    tick;
    mem_addr = 32'h4;
    #1;
    vectors++; if (mem_addr_ok !== 1'b1) begin miscompares++; $display("FAIL mr_ld1_addr_ok: got %b want 1", mem_addr_ok); end
    tick;
    mem_addr = 32'h0;
    #1;
    vectors++; if (mem_addr_ok !== 1'b0) begin miscompares++; $display("FAIL mr_ld2_refused: got %b want 0", mem_addr_ok); end
    mem_req = 1'b0; data_ok_resp = 1'b1;
    #1;
    vectors++; if (mem_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL mr_resp0: got %h want 0BADF00D", mem_rdata); end
    tick;
    vectors++; if (mem_rdata !== 32'hC0FFEE01) begin miscompares++; $display("FAIL mr_resp1: got %h want C0FFEE01", mem_rdata); end
    tick;
    vectors++; if (mem_data_ok !== 1'b0) begin miscompares++; $display("FAIL mr_drained: got %b want 0", mem_data_ok); end
  endtask

  task automatic test_wait_cycles;
    logic        exp_ok;
    logic [31:0] exp_dat;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_wstrb = 4'hF;
    mem_addr = 32'd36; mem_wdata = 32'h99990009;
    tick;
    mem_addr = 32'd40; mem_wdata = 32'hAAAA000A;
    tick;
    mem_we = 1'b0; mem_addr = 32'd36;
    #1;
    vectors++; if (w_addr_ok !== 1'b1) begin miscompares++; $display("FAIL wt_ld0_addr_ok: got %b want 1", w_addr_ok); end
    tick;
    mem_addr = 32'd40;
    #1;
    vectors++; if (w_addr_ok !== 1'b1) begin miscompares++; $display("FAIL wt_ld1_addr_ok: got %b want 1", w_addr_ok); end
    vectors++; if (w_data_ok !== 1'b0) begin miscompares++; $display("FAIL wt_dok_k0: got %b want 0", w_data_ok); end
    tick;
    mem_req = 1'b0;
    // k counts edges after the first load was accepted; pop of the first response happens at k=4.
    for (int k = 1; k <= 8; k++) begin
      exp_ok  = (k == 3) || (k == 7);
      exp_dat = (k == 3) ? 32'h99990009 : ((k == 7) ? 32'hAAAA000A : 32'h0);
      #1;
      vectors++; if (w_data_ok !== exp_ok) begin miscompares++; $display("FAIL wt_dok_k%0d: got %b want %b", k, w_data_ok, exp_ok); end
      vectors++; if (w_rdata !== exp_dat) begin miscompares++; $display("FAIL wt_rdata_k%0d: got %h want %h", k, w_rdata, exp_dat); end
      tick;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = 32'h0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    data_ok_resp = 1'b1;
    test_reset;
    test_store_load;
    test_back_to_back;
    test_full;
    test_wrap;
    test_mid_reset;
    test_wait_cycles;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
